// File: rtl/scoring_pkg.sv
// Shared types and constants for the scoring subsystem: player-ID widths,
// BCD limits and the login state encoding used by id_registry.
package scoring_pkg;

  localparam int ID_DIGITS = 4;
  localparam int INT_ID_W  = 3;
  localparam int LOOKUP_W  = 5;
  localparam int PID_W     = 4 * ID_DIGITS;

  localparam logic [3:0]          BCD_MAX  = 4'd9;
  localparam logic [INT_ID_W-1:0] GUEST_ID = '0;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    D1     = 4'd1,
    D2     = 4'd2,
    D3     = 4'd3,
    D4     = 4'd4,
    SEARCH = 4'd5,
    ALLOC  = 4'd6,
    DONE   = 4'd7,
    ERR    = 4'd8
  } regState_t;

  function automatic logic isBcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

  // Digit-collection states step D1 -> D2 -> D3 -> D4.
  function automatic regState_t nextDigitState(input regState_t cur);
    case (cur)
      D1:      return D2;
      D2:      return D3;
      default: return D4;
    endcase
  endfunction

endpackage

// File: rtl/id_table.sv
// Player-ID storage: DEPTH 16-bit entries with valid bits, one write port,
// a combinational compare port for the search, and a LAT-deep lookup pipe.
module id_table
  import scoring_pkg::*;
#(
  parameter int DEPTH = 7,
  parameter int LAT   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrEn,
  input  logic [INT_ID_W-1:0] wrIdx,
  input  logic [PID_W-1:0]    wrData,
  input  logic [INT_ID_W-1:0] cmpIdx,
  input  logic [PID_W-1:0]    cmpKey,
  output logic                cmpHit,
  input  logic [LOOKUP_W-1:0] rdIdx,
  output logic [PID_W-1:0]    rdData
);

  localparam int SLOTS = 1 << INT_ID_W;

  logic [PID_W-1:0] mem [SLOTS];
  logic [SLOTS-1:0] valid;
  logic             rdHit;
  logic [PID_W-1:0] rdRaw;
  logic [PID_W-1:0] pipe [LAT];

  // Slot 0 is the guest ID and is never written, so it never reads as valid.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrIdx] <= wrData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid <= '0;
    else if (wrEn) valid[wrIdx] <= 1'b1;
  end

  assign cmpHit = valid[cmpIdx] && (mem[cmpIdx] == cmpKey);

  assign rdHit = (rdIdx != '0) && (rdIdx <= LOOKUP_W'(DEPTH)) &&
                 valid[rdIdx[INT_ID_W-1:0]];
  assign rdRaw = rdHit ? mem[rdIdx[INT_ID_W-1:0]] : '0;

  // The first stage samples the array in the same edge that captures the
  // index, so a write landing on that edge is seen one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= rdRaw;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rdData = pipe[LAT-1];

endmodule

// File: rtl/id_registry.sv
// Player-ID registry: collects a 4-digit BCD login, finds or allocates a
// 3-bit internal ID, and answers the scorer's pipelined ID lookups.
module id_registry
  import scoring_pkg::*;
#(
  parameter int DEPTH = 7,
  parameter int LAT   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          digitIn,
  input  logic                digitValid,
  input  logic                isGuest,
  output logic [INT_ID_W-1:0] intID,
  output logic                loginDone,
  output logic                loginErr,
  output logic                busy,
  input  logic [LOOKUP_W-1:0] lookupID,
  output logic [PID_W-1:0]    topID,
  output regState_t           dbgState
);

  localparam logic [INT_ID_W-1:0] DEPTH_ID = INT_ID_W'(DEPTH);

  regState_t           state;
  logic [PID_W-1:0]    key;
  logic [INT_ID_W-1:0] count;
  logic [INT_ID_W-1:0] srchIdx;
  logic                wrEn;
  logic [INT_ID_W-1:0] wrIdx;
  logic                cmpHit;

  assign wrEn     = (state == ALLOC);
  assign wrIdx    = count + INT_ID_W'(1);
  assign dbgState = state;

  id_table #(
    .DEPTH(DEPTH),
    .LAT  (LAT)
  ) uTable (
    .clk   (clk),
    .rst   (rst),
    .wrEn  (wrEn),
    .wrIdx (wrIdx),
    .wrData(key),
    .cmpIdx(srchIdx),
    .cmpKey(key),
    .cmpHit(cmpHit),
    .rdIdx (lookupID),
    .rdData(topID)
  );

  // Digits shift in from the right; after four strobes the first digit
  // sits in [15:12]. Pulses are raised on entry to DONE / ERR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      key       <= '0;
      count     <= '0;
      srchIdx   <= '0;
      intID     <= GUEST_ID;
      loginDone <= 1'b0;
      loginErr  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      loginDone <= 1'b0;
      loginErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (isGuest) begin
            intID     <= GUEST_ID;
            loginDone <= 1'b1;
            busy      <= 1'b1;
            state     <= DONE;
          end else if (digitValid) begin
            key  <= {key[PID_W-5:0], digitIn};
            busy <= 1'b1;
            if (!isBcd(digitIn)) begin
              loginErr <= 1'b1;
              state    <= ERR;
            end else begin
              state <= D1;
            end
          end
        end
        D1, D2, D3: begin
          if (digitValid) begin
            key <= {key[PID_W-5:0], digitIn};
            if (!isBcd(digitIn)) begin
              loginErr <= 1'b1;
              state    <= ERR;
            end else begin
              state <= nextDigitState(state);
            end
          end
        end
        D4: begin
          srchIdx <= INT_ID_W'(1);
          state   <= (count == '0) ? ALLOC : SEARCH;
        end
        SEARCH: begin
          if (cmpHit) begin
            intID     <= srchIdx;
            loginDone <= 1'b1;
            state     <= DONE;
          end else if (srchIdx == count) begin
            if (count < DEPTH_ID) begin
              state <= ALLOC;
            end else begin
              loginErr <= 1'b1;
              state    <= ERR;
            end
          end else begin
            srchIdx <= srchIdx + INT_ID_W'(1);
          end
        end
        ALLOC: begin
          count     <= wrIdx;
          intID     <= wrIdx;
          loginDone <= 1'b1;
          state     <= DONE;
        end
        DONE, ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_registry.sv
// Bench for id_registry: directed logins against a table/latency model with a
// per-cycle output compare, plus literal checks from hand-worked scenarios.
module tb_id_registry;
  import scoring_pkg::*;

  localparam int DEPTH = 7;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  digitIn = '0;
  logic        digitValid = 1'b0;
  logic        isGuest = 1'b0;
  logic [4:0]  lookupID = '0;
  logic [2:0]  intID;
  logic        loginDone;
  logic        loginErr;
  logic        busy;
  logic [15:0] topID;
  regState_t   dbgState;

  id_registry #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .digitIn   (digitIn),
    .digitValid(digitValid),
    .isGuest   (isGuest),
    .intID     (intID),
    .loginDone (loginDone),
    .loginErr  (loginErr),
    .busy      (busy),
    .lookupID  (lookupID),
    .topID     (topID),
    .dbgState  (dbgState)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected login outcome: pulse cycle, first busy cycle, kind, result.
  typedef struct {
    int         pulseCyc;
    int         busyStart;
    bit         isErr;
    logic [2:0] id;
  } ev_t;

  ev_t         expQ[$];
  int          nAssert = 0;
  int          nFail = 0;
  int          lastPulse = 0;
  logic [15:0] tab [1:DEPTH];
  int          doneCyc [1:DEPTH];
  int          regCount = 0;
  logic [2:0]  modelInt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  logic [4:0]  h1 = '0;
  logic [4:0]  h2 = '0;
  logic        expDone, expErr, expBusy;
  logic [15:0] expTop;
  int          lkIdx;

  always @(negedge clk) begin
    if (!rst) begin
      h1 = '0;
      h2 = '0;
    end else begin
      expDone = 1'b0;
      expErr  = 1'b0;
      expBusy = 1'b0;
      if (expQ.size() > 0) begin
        expBusy = (cyc >= expQ[0].busyStart) && (cyc <= expQ[0].pulseCyc);
        if (expQ[0].pulseCyc == cyc) begin
          expDone = !expQ[0].isErr;
          expErr  = expQ[0].isErr;
          if (!expQ[0].isErr) modelInt = expQ[0].id;
        end
      end
      lkIdx  = int'(h2);
      expTop = '0;
      if (lkIdx >= 1 && lkIdx <= regCount && doneCyc[lkIdx] <= cyc - 2) expTop = tab[lkIdx];
      check("busy", 32'(busy), 32'(expBusy));
      check("loginDone", 32'(loginDone), 32'(expDone));
      check("loginErr", 32'(loginErr), 32'(expErr));
      check("intID", 32'(intID), 32'(modelInt));
      check("topID", 32'(topID), 32'(expTop));
      if (loginDone || loginErr) lastPulse = cyc;
      if (expQ.size() > 0 && expQ[0].pulseCyc <= cyc) void'(expQ.pop_front());
      h2 = h1;
      h1 = lookupID;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitPast(input int c);
    while (cyc <= c) tick();
    tick();
  endtask

  // Drives the digits of pid on consecutive cycles; returns the last strobe cycle.
  task automatic login(input logic [15:0] pid, output int lastStrobe);
    ev_t        e;
    int         c0;
    int         bad;
    int         found;
    int         last;
    logic [3:0] d [4];
    bad = -1;
    for (int i = 0; i < 4; i++) begin
      d[i] = pid[15-4*i -: 4];
      if (bad < 0 && d[i] > 4'd9) bad = i;
    end
    tick();
    c0 = cyc;
    e.busyStart = c0 + 1;
    e.id = '0;
    e.isErr = 1'b0;
    last = (bad >= 0) ? bad : 3;
    if (bad >= 0) begin
      e.isErr = 1'b1;
      e.pulseCyc = c0 + bad + 1;
    end else begin
      found = 0;
      for (int j = 1; j <= regCount; j++) if (found == 0 && tab[j] == pid) found = j;
      if (found != 0) begin
        e.pulseCyc = c0 + 3 + 2 + found;
        e.id = 3'(found);
      end else if (regCount < DEPTH) begin
        e.pulseCyc = c0 + 3 + 3 + regCount;
        regCount++;
        tab[regCount] = pid;
        doneCyc[regCount] = e.pulseCyc;
        e.id = 3'(regCount);
      end else begin
        e.isErr = 1'b1;
        e.pulseCyc = c0 + 3 + 2 + DEPTH;
      end
    end
    expQ.push_back(e);
    for (int i = 0; i <= last; i++) begin
      digitValid = 1'b1;
      digitIn = d[i];
      tick();
    end
    digitValid = 1'b0;
    digitIn = '0;
    lastStrobe = c0 + last;
    waitPast(e.pulseCyc);
  endtask

  task automatic guest();
    ev_t e;
    tick();
    e.pulseCyc = cyc + 1;
    e.busyStart = cyc + 1;
    e.isErr = 1'b0;
    e.id = GUEST_ID;
    expQ.push_back(e);
    isGuest = 1'b1;
    tick();
    isGuest = 1'b0;
    waitPast(e.pulseCyc);
  endtask

  task automatic lookupCheck(input logic [4:0] id, input logic [15:0] want, input string name);
    tick();
    lookupID = id;
    tick();
    tick();
    @(negedge clk);
    check(name, 32'(topID), 32'(want));
  endtask

  task automatic clearModel();
    expQ.delete();
    modelInt = '0;
    regCount = 0;
    for (int j = 1; j <= DEPTH; j++) doneCyc[j] = 32'h7fff_ffff;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  int s;
  ev_t abortEv;

  initial begin
    clearModel();
    repeat (3) tick();
    check("reset intID", 32'(intID), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset loginDone", 32'(loginDone), 32'd0);
    check("reset topID", 32'(topID), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    login(16'h1234, s);
    check("first login id", 32'(intID), 32'd1);
    check("first login latency", 32'(lastPulse - s), 32'd3);
    lookupCheck(5'd1, 16'h1234, "lookup 1 after first login");

    login(16'h1234, s);
    check("relogin id", 32'(intID), 32'd1);
    check("relogin latency", 32'(lastPulse - s), 32'd3);

    login(16'h5678, s);
    check("second player id", 32'(intID), 32'd2);
    check("second player latency", 32'(lastPulse - s), 32'd4);

    guest();
    check("guest id", 32'(intID), 32'd0);
    lookupCheck(5'd0, 16'h0000, "lookup guest");
    lookupCheck(5'd9, 16'h0000, "lookup out of range");

    login(16'h12A0, s);
    check("bad digit latency", 32'(lastPulse - s), 32'd1);
    check("bad digit keeps id", 32'(intID), 32'd0);
    login(16'h9012, s);
    check("login after error", 32'(intID), 32'd3);

    tick();
    lookupID = 5'd4;
    login(16'h1111, s);
    check("fourth player", 32'(intID), 32'd4);
    login(16'h2222, s);
    login(16'h3333, s);
    login(16'h4444, s);
    check("seventh player", 32'(intID), 32'd7);
    login(16'h8888, s);
    check("table full latency", 32'(lastPulse - s), 32'd9);
    check("table full keeps id", 32'(intID), 32'd7);
    login(16'h9012, s);
    check("third player relogin", 32'(intID), 32'd3);
    lookupCheck(5'd3, 16'h9012, "lookup 3");

    // Abort a login with reset while two digits are in.
    tick();
    abortEv.pulseCyc = cyc + 100000;
    abortEv.busyStart = cyc + 1;
    abortEv.isErr = 1'b0;
    abortEv.id = '0;
    expQ.push_back(abortEv);
    digitValid = 1'b1;
    digitIn = 4'd4;
    tick();
    digitIn = 4'd3;
    tick();
    digitValid = 1'b0;
    check("in D2 before reset", 32'(dbgState), 32'(D2));
    rst = 1'b0;
    clearModel();
    #1;
    check("async reset intID", 32'(intID), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset topID", 32'(topID), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    lookupCheck(5'd1, 16'h0000, "lookup 1 after reset");
    login(16'h4321, s);
    check("first login after reset", 32'(intID), 32'd1);
    lookupCheck(5'd1, 16'h4321, "lookup 1 new player");

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
